banked_register_block: RTL and testbench
========================================

// Module: banked_register_block
// PURPOSE
//  Parametrised uCISC register block: PC passthrough, r1..r3 and flags, held in NUM_BANKS switchable banks.
//  Sits between decode and ALU/mem-address path. Produces source/destination operands with immediate
//  offset and pre-increment, and applies post-increment, register and flag writes each cycle.
//  Adds bank switching for interrupt context entry/exit via a req/ack handshake and a small FSM.
// PARAMETERS
//  WIDTH      16  datapath width of pc, r1..r3, flags, operands
//  IMM_WIDTH  7   immediate width; sign-extended to WIDTH
//  NUM_BANKS  2   register banks (>=1); BANK_W = max(1,$clog2(NUM_BANKS))
// PORTS
//  clock               in   1          sole clock, rising edge
//  reset               in   1          synchronous, active-high
//  pc                  in   WIDTH      current program counter
//  source_select       in   3          0 pc, 1-3 r1-r3 (mem), 4 imm/flags, 5-7 r1-r3 (direct)
//  destination_select  in   3          same encoding; 4 = flags
//  source_immediate    in   1          select 4 source: 1 immediate, 0 flags_value
//  immediate           in   IMM_WIDTH  signed offset
//  destination_write   in   WIDTH      value for store_value
//  flags_value         in   WIDTH      ALU flags result
//  set_flags           in   1          write flags_value into flags
//  store_value         in   1          write destination_write to selected destination
//  pre_increment       in   1          offset destination_out by +/-1
//  post_increment      in   1          step selected address reg by +/-1 at clock edge
//  decrement           in   1          increment value -1 instead of +1
//  bank_req            in   1          request bank switch (level, held until bank_ack)
//  bank_sel            in   BANK_W     target bank
//  bank_ack            out  1          1-cycle pulse: switch complete
//  busy                out  1          switch in progress; core must stall
//  current_bank        out  BANK_W     active bank
//  source_out          out  WIDTH      source operand
//  destination_out     out  WIDTH      destination operand/address
//  flags_out           out  WIDTH      active-bank flags
// BEHAVIOUR
//  Reset: all banks r1..r3=0, flags=0; current_bank=0; bank_ack=0; busy=0; FSM IDLE.
//  Operands combinational from active bank, all WIDTH-bit wrap-around arithmetic:
//   source_out = base(source_select) + sext(immediate). Select 4 with source_immediate=1 gives
//   sext(immediate) only, never doubled. Select 4 with source_immediate=0 gives flags_value + sext(immediate).
//   destination_out = base(destination_select) + (pre_increment ? (decrement ? -1 : +1) : 0).
//   Destination select 4 base is flags_value.
//  Writes, active bank, at posedge, only while FSM IDLE:
//   flags: set_flags wins over store_value with dest 4.
//   r1..r3 store: only when store_value and dest select is 5-7.
//   Post-increment target: dest select 1-3 if any, else source select 1-3. Dest has priority; one reg max.
//   Store and post-increment on the same reg in the same cycle: store wins.
//  Bank FSM:
//   IDLE -> SWITCH when bank_req && bank_sel != current_bank.
//    That cycle's writes still land in the old bank.
//    bank_sel >= NUM_BANKS is ignored (stay IDLE, no ack).
//   IDLE with bank_req && bank_sel == current_bank: bank_ack pulses next cycle; no busy.
//   SWITCH: busy=1 for 1 cycle; current_bank <= bank_sel; -> ACK.
//   ACK: bank_ack=1, busy=0, -> IDLE. A req still high in IDLE is re-evaluated (same bank, so immediate ack).
//   While busy, store_value/set_flags/post_increment are ignored; operands read the old bank.
//  Reset mid-switch: returns to IDLE, bank 0, no ack.
// CONFIGURATION
//  REGBANK_COPY_ON_SWITCH_EN defined:
//   SWITCH is followed by COPY states copying r1,r2,r3 of old bank into new bank, 1 reg/cycle.
//   A 2-bit counter tracks the copy; busy stays high for 4 cycles total; flags are not copied.
//  Undefined: no copy; the new bank keeps its own contents.
// STRUCTURE
//  Package uc_regbank_pkg: select encodings (SEL_PC=0, SEL_FLAGS=4, direct bit [2]), FSM state enum,
//   increment helper function.
//  Sub-module: regbank_switch_fsm (req/ack, busy, current_bank, copy counter).
//  Storage and operand muxing stay in banked_register_block.
// TESTING
//  Reset, src=5, imm=7'h7F -> source_out=16'hFFFF; flags_out=0; current_bank=0.
//  r1=16'h0010, dest=1, pre_inc, decrement -> destination_out=16'h000F.
//   post_inc with store to dest 5 same cycle -> r1=destination_write.
//  set_flags=1, flags_value=16'h0003, store to dest 4 with 16'h00AA -> flags_out=16'h0003.
//  r2=16'hFFFF, src=2, post_inc -> r2 wraps to 16'h0000.
//   dest=3, src=2, post_inc -> only r3 steps.
//  Bank 0 r1=5; bank_req, bank_sel=1 -> busy 1 cycle, bank_ack next cycle.
//   Bank 1 r1=0 (copy off) or 5 (REGBANK_COPY_ON_SWITCH_EN, busy 4 cycles). Switch back -> r1=5.
//  Assert reset during SWITCH -> next cycle current_bank=0, busy=0, bank_ack=0.

Source files
------------

// File: rtl/uc_regbank_pkg.sv
// uc_regbank_pkg: shared encodings for the banked uCISC register block.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
// Contents: operand select encodings, bank-switch FSM state enum, +/-1 step helper.
package uc_regbank_pkg;

  // Operand select encodings. Selects 1-3 address r1..r3 as memory operands,
  // 5-7 address the same registers directly (bit 2 set).
  localparam logic [2:0] SEL_PC         = 3'd0;
  localparam logic [2:0] SEL_FLAGS      = 3'd4;
  localparam int         SEL_DIRECT_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWITCH = 2'd1,
    ST_COPY   = 2'd2,
    ST_ACK    = 2'd3
  } bank_state_t;

  // Two-bit signed step (+1 or -1); callers sign-extend to the datapath width.
  function automatic logic [1:0] inc_step(input logic dec);
    return dec ? 2'b11 : 2'b01;
  endfunction

endpackage

// File: rtl/banked_register_block_switch_fsm.sv
// regbank_switch_fsm: req/ack bank-switch sequencer for banked_register_block.
// Latency: ack one cycle after a same-bank req; busy for 1 cycle (4 with copy) then ack.
// Backpressure: busy stalls the core; register writes are enabled only while idle.
// Optional: REGBANK_COPY_ON_SWITCH_EN adds three copy cycles (r1,r2,r3 old->new bank).
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_bank_req, i_bank_sel  level request and target bank
//   o_bank_ack, o_busy      one-cycle completion pulse, switch in progress
//   o_current_bank          active bank
//   o_wr_en                 register/flag writes allowed (FSM idle)
//   o_copy_vld, o_copy_idx  copy register index 0..2 this cycle
//   o_copy_src_bank         bank being copied from
module regbank_switch_fsm
  import uc_regbank_pkg::*;
#(
  parameter int  NUM_BANKS = 2,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_bank_req,
  input  logic [BANK_W-1:0] i_bank_sel,
  output logic              o_bank_ack,
  output logic              o_busy,
  output logic [BANK_W-1:0] o_current_bank,
  output logic              o_wr_en,
  output logic              o_copy_vld,
  output logic [1:0]        o_copy_idx,
  output logic [BANK_W-1:0] o_copy_src_bank
);

  localparam logic [BANK_W:0] NB = NUM_BANKS[BANK_W:0];

  bank_state_t       r_state;
  logic              r_ack;
  logic              r_busy;
  logic              r_wr_en;
  logic              r_copy_vld;
  logic [1:0]        r_cnt;
  logic [BANK_W-1:0] r_cur;
  logic [BANK_W-1:0] r_old;
  logic [BANK_W-1:0] r_target;
  logic              w_sel_ok;

  // Requests for a bank that does not exist are dropped silently.
  assign w_sel_ok = ({1'b0, i_bank_sel} < NB);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_en    <= 1'b1;
      r_copy_vld <= 1'b0;
      r_cnt      <= 2'd0;
      r_cur      <= '0;
      r_old      <= '0;
      r_target   <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_bank_req && w_sel_ok) begin
            if (i_bank_sel == r_cur) begin
              r_ack <= 1'b1;
            end else begin
              r_state  <= ST_SWITCH;
              r_busy   <= 1'b1;
              r_wr_en  <= 1'b0;
              r_target <= i_bank_sel;
            end
          end
        end
        ST_SWITCH: begin
          r_cur <= r_target;
          r_old <= r_cur;
`ifdef REGBANK_COPY_ON_SWITCH_EN
          r_state    <= ST_COPY;
          r_cnt      <= 2'd0;
          r_copy_vld <= 1'b1;
`else
          r_state <= ST_ACK;
          r_busy  <= 1'b0;
          r_ack   <= 1'b1;
`endif
        end
        ST_COPY: begin
          // Counter walks r1,r2,r3; the last copy cycle hands over to ACK.
          if (r_cnt == 2'd2) begin
            r_state    <= ST_ACK;
            r_copy_vld <= 1'b0;
            r_busy     <= 1'b0;
            r_ack      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wr_en <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_bank_ack      = r_ack;
  assign o_busy          = r_busy;
  assign o_current_bank  = r_cur;
  assign o_wr_en         = r_wr_en;
  assign o_copy_vld      = r_copy_vld;
  assign o_copy_idx      = r_cnt;
  assign o_copy_src_bank = r_old;

endmodule

// File: rtl/banked_register_block.sv
// banked_register_block: uCISC register block (pc passthrough, r1..r3, flags) in NUM_BANKS banks.
// Latency: operands combinational from the active bank; writes land at the next rising edge.
// Backpressure: o_busy high during a bank switch; writes ignored until the FSM is idle again.
// Optional: REGBANK_COPY_ON_SWITCH_EN copies r1..r3 from the old bank into the new bank on switch.
// Ports:
//   i_clock, i_reset                    clock, synchronous active-high reset
//   i_pc                                program counter (select 0 base)
//   i_source_select/i_destination_select 0 pc, 1-3 r1-r3 mem, 4 imm/flags, 5-7 r1-r3 direct
//   i_source_immediate, i_immediate     select-4 source mode, signed offset
//   i_destination_write, i_flags_value  store data, ALU flags
//   i_set_flags, i_store_value          flag write, register/flag store
//   i_pre_increment, i_post_increment, i_decrement  +/-1 adjustments
//   i_bank_req, i_bank_sel, o_bank_ack, o_busy, o_current_bank  bank switch handshake
//   o_source_out, o_destination_out, o_flags_out                operands and active flags
module banked_register_block
  import uc_regbank_pkg::*;
#(
  parameter int  WIDTH     = 16,
  parameter int  IMM_WIDTH = 7,
  parameter int  NUM_BANKS = 2,
  localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic [WIDTH-1:0]     i_pc,
  input  logic [2:0]           i_source_select,
  input  logic [2:0]           i_destination_select,
  input  logic                 i_source_immediate,
  input  logic [IMM_WIDTH-1:0] i_immediate,
  input  logic [WIDTH-1:0]     i_destination_write,
  input  logic [WIDTH-1:0]     i_flags_value,
  input  logic                 i_set_flags,
  input  logic                 i_store_value,
  input  logic                 i_pre_increment,
  input  logic                 i_post_increment,
  input  logic                 i_decrement,
  input  logic                 i_bank_req,
  input  logic [BANK_W-1:0]    i_bank_sel,
  output logic                 o_bank_ack,
  output logic                 o_busy,
  output logic [BANK_W-1:0]    o_current_bank,
  output logic [WIDTH-1:0]     o_source_out,
  output logic [WIDTH-1:0]     o_destination_out,
  output logic [WIDTH-1:0]     o_flags_out
);

  logic [WIDTH-1:0] r_regs  [NUM_BANKS][3];
  logic [WIDTH-1:0] r_flags [NUM_BANKS];

  logic              w_wr_en;
  logic              w_copy_vld;
  logic [1:0]        w_copy_idx;
  logic [BANK_W-1:0] w_copy_src;
  logic [BANK_W-1:0] w_cur;
  logic [1:0]        w_step2;
  logic [WIDTH-1:0]  w_step;
  logic [WIDTH-1:0]  w_imm;
  logic [WIDTH-1:0]  w_src_reg;
  logic [WIDTH-1:0]  w_dst_reg;
  logic [WIDTH-1:0]  w_src_base;
  logic [WIDTH-1:0]  w_dst_base;
  logic [1:0]        w_src_idx;
  logic [1:0]        w_dst_idx;
  logic              w_src_mem;
  logic              w_dst_mem;
  logic              w_dst_dir;
  logic [2:0]        w_store_hit;
  logic [2:0]        w_post_hit;

  regbank_switch_fsm #(
    .NUM_BANKS (NUM_BANKS)
  ) u_switch_fsm (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_bank_req      (i_bank_req),
    .i_bank_sel      (i_bank_sel),
    .o_bank_ack      (o_bank_ack),
    .o_busy          (o_busy),
    .o_current_bank  (w_cur),
    .o_wr_en         (w_wr_en),
    .o_copy_vld      (w_copy_vld),
    .o_copy_idx      (w_copy_idx),
    .o_copy_src_bank (w_copy_src)
  );

  assign o_current_bank = w_cur;

  assign w_step2 = inc_step(i_decrement);
  assign w_step  = {{(WIDTH-2){w_step2[1]}}, w_step2};
  assign w_imm   = {{(WIDTH-IMM_WIDTH){i_immediate[IMM_WIDTH-1]}}, i_immediate};

  assign w_src_idx = i_source_select[1:0];
  assign w_dst_idx = i_destination_select[1:0];
  // Register selects: non-zero low bits; bit 2 distinguishes direct (5-7) from memory (1-3).
  assign w_src_mem = (w_src_idx != 2'd0) && !i_source_select[SEL_DIRECT_BIT];
  assign w_dst_mem = (w_dst_idx != 2'd0) && !i_destination_select[SEL_DIRECT_BIT];
  assign w_dst_dir = (w_dst_idx != 2'd0) &&  i_destination_select[SEL_DIRECT_BIT];

  always_comb begin
    w_src_reg = '0;
    w_dst_reg = '0;
    if (w_src_idx != 2'd0) w_src_reg = r_regs[w_cur][w_src_idx - 2'd1];
    if (w_dst_idx != 2'd0) w_dst_reg = r_regs[w_cur][w_dst_idx - 2'd1];

    if (i_source_select == SEL_PC)         w_src_base = i_pc;
    else if (i_source_select == SEL_FLAGS) w_src_base = i_flags_value;
    else                                   w_src_base = w_src_reg;

    if (i_destination_select == SEL_PC)         w_dst_base = i_pc;
    else if (i_destination_select == SEL_FLAGS) w_dst_base = i_flags_value;
    else                                        w_dst_base = w_dst_reg;
  end

  // Select 4 in immediate mode yields the immediate alone rather than base + offset.
  assign o_source_out = (i_source_select == SEL_FLAGS && i_source_immediate) ?
                        w_imm : (w_src_base + w_imm);
  assign o_destination_out = w_dst_base + (i_pre_increment ? w_step : '0);
  assign o_flags_out = r_flags[w_cur];

  always_comb begin
    w_store_hit = 3'b000;
    w_post_hit  = 3'b000;
    if (i_store_value && w_dst_dir) w_store_hit = 3'b001 << (w_dst_idx - 2'd1);
    // Post-increment steps at most one register; the destination wins over the source.
    if (i_post_increment) begin
      if (w_dst_mem)      w_post_hit = 3'b001 << (w_dst_idx - 2'd1);
      else if (w_src_mem) w_post_hit = 3'b001 << (w_src_idx - 2'd1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_flags[b] <= '0;
        for (int k = 0; k < 3; k++) r_regs[b][k] <= '0;
      end
    end else if (w_wr_en) begin
      if (i_set_flags) begin
        r_flags[w_cur] <= i_flags_value;
      end else if (i_store_value && i_destination_select == SEL_FLAGS) begin
        r_flags[w_cur] <= i_destination_write;
      end
      for (int k = 0; k < 3; k++) begin
        if (w_store_hit[k])     r_regs[w_cur][k] <= i_destination_write;
        else if (w_post_hit[k]) r_regs[w_cur][k] <= r_regs[w_cur][k] + w_step;
      end
    end else if (w_copy_vld && w_copy_idx != 2'd3) begin
      r_regs[w_cur][w_copy_idx] <= r_regs[w_copy_src][w_copy_idx];
    end
  end

endmodule

// File: tb/tb_banked_register_block.sv
module tb_banked_register_block;

`ifdef REGBANK_COPY_ON_SWITCH_EN
  localparam int BUSY_CYC = 4;
  localparam bit COPY_EN  = 1'b1;
`else
  localparam int BUSY_CYC = 1;
  localparam bit COPY_EN  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic [2:0]  src_sel, dst_sel;
  logic        src_imm;
  logic [6:0]  imm;
  logic [15:0] dwrite, fval;
  logic        set_flags, store, pre_inc, post_inc, dec;
  logic        bank_req;
  logic [0:0]  bank_sel;
  logic        bank_ack, busy;
  logic [0:0]  cur_bank;
  logic [15:0] src_out, dst_out, flags_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  banked_register_block dut (
    .i_clock              (clk),
    .i_reset              (reset),
    .i_pc                 (pc),
    .i_source_select      (src_sel),
    .i_destination_select (dst_sel),
    .i_source_immediate   (src_imm),
    .i_immediate          (imm),
    .i_destination_write  (dwrite),
    .i_flags_value        (fval),
    .i_set_flags          (set_flags),
    .i_store_value        (store),
    .i_pre_increment      (pre_inc),
    .i_post_increment     (post_inc),
    .i_decrement          (dec),
    .i_bank_req           (bank_req),
    .i_bank_sel           (bank_sel),
    .o_bank_ack           (bank_ack),
    .o_busy               (busy),
    .o_current_bank       (cur_bank),
    .o_source_out         (src_out),
    .o_destination_out    (dst_out),
    .o_flags_out          (flags_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    src_sel = 3'd0; dst_sel = 3'd0; src_imm = 1'b0; imm = 7'd0;
    dwrite = 16'd0; fval = 16'd0; set_flags = 1'b0; store = 1'b0;
    pre_inc = 1'b0; post_inc = 1'b0; dec = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] sel, input logic [15:0] v);
    quiet();
    dst_sel = sel; dwrite = v; store = 1'b1;
    tick();
    quiet();
  endtask

  // Read rN directly (select 5-7, zero offset).
  task automatic read_reg(input logic [2:0] sel, input string tag, input logic [15:0] exp);
    quiet();
    src_sel = sel;
    #1;
    check(tag, {16'd0, src_out}, {16'd0, exp});
  endtask

  // Raise req, count busy cycles (bounded), then check ack and new bank.
  task automatic do_switch(input logic [0:0] target, input string tag);
    int n;
    bank_req = 1'b1; bank_sel = target;
    tick();
    n = 0;
    while (busy && n < 10) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, BUSY_CYC);
    check({tag, "_ack"}, {31'd0, bank_ack}, 32'd1);
    check({tag, "_bank"}, {31'd0, cur_bank}, {31'd0, target});
    bank_req = 1'b0;
    tick();
    check({tag, "_ack_drop"}, {31'd0, bank_ack}, 32'd0);
  endtask

  initial begin
    quiet();
    pc = 16'h0000; bank_req = 1'b0; bank_sel = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state; r1=0 plus sext(7'h7F)=-1 wraps to FFFF.
    src_sel = 3'd5; imm = 7'h7F;
    #1;
    check("rst_src", {16'd0, src_out}, 32'h0000FFFF);
    check("rst_flags", {16'd0, flags_out}, 32'd0);
    check("rst_bank", {31'd0, cur_bank}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ack", {31'd0, bank_ack}, 32'd0);

    // Operand paths.
    write_reg(3'd5, 16'h0010);
    dst_sel = 3'd1; pre_inc = 1'b1; dec = 1'b1; #1;
    check("pre_dec", {16'd0, dst_out}, 32'h0000000F);
    dec = 1'b0; #1;
    check("pre_inc", {16'd0, dst_out}, 32'h00000011);
    quiet(); src_sel = 3'd4; src_imm = 1'b1; imm = 7'h05; fval = 16'h0100; #1;
    check("imm_only", {16'd0, src_out}, 32'h00000005);
    src_imm = 1'b0; imm = 7'h7E; #1;
    check("flags_plus_imm", {16'd0, src_out}, 32'h000000FE);
    quiet(); pc = 16'h1234; src_sel = 3'd0; imm = 7'h03; dst_sel = 3'd0; pre_inc = 1'b1; #1;
    check("pc_src", {16'd0, src_out}, 32'h00001237);
    check("pc_dst_inc", {16'd0, dst_out}, 32'h00001235);
    quiet(); dst_sel = 3'd4; fval = 16'h0055; #1;
    check("dst_flags", {16'd0, dst_out}, 32'h00000055);

    // Store beats post-increment on the same register.
    quiet(); src_sel = 3'd1; post_inc = 1'b1; store = 1'b1; dst_sel = 3'd5; dwrite = 16'hBEEF;
    tick();
    read_reg(3'd5, "store_wins", 16'hBEEF);
    quiet(); src_sel = 3'd1; post_inc = 1'b1;
    tick();
    read_reg(3'd5, "post_inc_src", 16'hBEF0);

    // set_flags beats a flags store.
    quiet(); set_flags = 1'b1; fval = 16'h0003; store = 1'b1; dst_sel = 3'd4; dwrite = 16'h00AA;
    tick();
    quiet(); #1;
    check("flags_prio", {16'd0, flags_out}, 32'h00000003);
    write_reg(3'd4, 16'h00AA);
    #1;
    check("flags_store", {16'd0, flags_out}, 32'h000000AA);

    // Wrap and post-increment target priority.
    write_reg(3'd6, 16'hFFFF);
    quiet(); src_sel = 3'd2; post_inc = 1'b1;
    tick();
    read_reg(3'd6, "r2_wrap", 16'h0000);
    quiet(); dst_sel = 3'd3; src_sel = 3'd2; post_inc = 1'b1;
    tick();
    read_reg(3'd7, "r3_step", 16'h0001);
    read_reg(3'd6, "r2_untouched", 16'h0000);

    // Same-bank request: ack next cycle, never busy.
    quiet(); bank_req = 1'b1; bank_sel = 1'b0;
    tick();
    check("same_ack", {31'd0, bank_ack}, 32'd1);
    check("same_busy", {31'd0, busy}, 32'd0);
    bank_req = 1'b0;
    tick();
    check("same_ack_drop", {31'd0, bank_ack}, 32'd0);

    // Switch to bank 1: request-cycle store lands in bank 0; stores while busy are dropped.
    write_reg(3'd5, 16'h0005);
    quiet(); store = 1'b1; dst_sel = 3'd6; dwrite = 16'h0077;
    bank_req = 1'b1; bank_sel = 1'b1;
    tick();
    check("sw_busy", {31'd0, busy}, 32'd1);
    check("sw_old_bank", {31'd0, cur_bank}, 32'd0);
    dst_sel = 3'd5; dwrite = 16'hDEAD;
    begin
      int n;
      n = 1;
      while (busy && n < 10) begin
        tick();
        if (busy) n++;
      end
      check("sw_busy_cycles", n, BUSY_CYC);
    end
    check("sw_ack", {31'd0, bank_ack}, 32'd1);
    check("sw_new_bank", {31'd0, cur_bank}, 32'd1);
    quiet(); bank_req = 1'b0;
    tick();
    check("sw_ack_drop", {31'd0, bank_ack}, 32'd0);
    read_reg(3'd5, "b1_r1", COPY_EN ? 16'h0005 : 16'h0000);
    read_reg(3'd6, "b1_r2", COPY_EN ? 16'h0077 : 16'h0000);
    #1;
    check("b1_flags", {16'd0, flags_out}, 32'd0);

    do_switch(1'b0, "back");
    read_reg(3'd5, "b0_r1", 16'h0005);
    read_reg(3'd6, "b0_r2", 16'h0077);
    #1;
    check("b0_flags", {16'd0, flags_out}, 32'h000000AA);

    // Reset while switching.
    quiet(); bank_req = 1'b1; bank_sel = 1'b1;
    tick();
    check("rs_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    check("rs_bank", {31'd0, cur_bank}, 32'd0);
    check("rs_busy0", {31'd0, busy}, 32'd0);
    check("rs_ack0", {31'd0, bank_ack}, 32'd0);
    reset = 1'b0; bank_req = 1'b0;
    tick();
    check("rs_ack_after", {31'd0, bank_ack}, 32'd0);
    read_reg(3'd5, "rs_r1", 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
